multicycle_controller: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects. It produces the 2-bit aluop and a stable opcode that the ALU decoder consumes. It also stalls on a memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 62 ++++++
 rtl/mips_ctrl_outdec.sv | 88 ++++++++
 rtl/multicycle_controller.sv | 91 +++++++++
 tb/tb_multicycle_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, ALU op classes,
// FSM states and datapath mux selects.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ITYPE = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StAluWb   = 4'd7,
    StBeq     = 4'd8,
    StItypeEx = 4'd9,
    StItypeWb = 4'd10,
    StJump    = 4'd11
  } state_e;

  // Dispatch out of DECODE; StFetch doubles as the "unsupported opcode" result.
  function automatic state_e decode_next(logic [5:0] op);
    state_e nxt;
    unique case (op)
      OP_LW, OP_SW:                      nxt = StMemAdr;
      OP_RTYPE:                          nxt = StRtypeEx;
      OP_BEQ:                            nxt = StBeq;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = StItypeEx;
      OP_J:                              nxt = StJump;
      default:                           nxt = StFetch;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state-to-control decode for the multicycle MIPS controller.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  op_q,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        adr_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic [1:0]  result_src,
  output logic [1:0]  pc_src,
  output logic [1:0]  aluop
);

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    imm_zext   = 1'b0;
    result_src = RES_ALUOUT;
    pc_src     = PCSRC_ALURESULT;
    aluop      = ALUOP_ADD;
    case (state)
      StFetch: begin
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      // Precompute the branch target into ALUOut while the opcode is decoded.
      StDecode:  alu_src_b = SRCB_BRANCH;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      StMemRd:   adr_src = 1'b1;
      StMemWb: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StRtypeEx: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_RTYPE;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBeq: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = PCSRC_ALUOUT;
      end
      StItypeEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_ITYPE;
        imm_zext  = (op_q == OP_ANDI) || (op_q == OP_ORI);
      end
      StItypeWb: reg_write = 1'b1;
      StJump: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// and drives the datapath enables and mux selects.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               adr_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [1:0]         result_src,
  output logic [1:0]         pc_src,
  output logic [1:0]         aluop,
  output logic [5:0]         alu_opcode,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic       illegal_q;
  logic       dec_ir_write, dec_pc_write, dec_branch, dec_mem_write, dec_reg_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == StDecode) && (decode_next(opcode) == StFetch);
      if (state_q == StDecode) begin
        op_q <= opcode;
      end
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:   state_d = mem_ready ? StDecode : StFetch;
      StDecode:  state_d = decode_next(opcode);
      StMemAdr:  state_d = (op_q == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
      StRtypeEx: state_d = StAluWb;
      StItypeEx: state_d = StItypeWb;
      default:   state_d = StFetch;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state      (state_q),
    .op_q       (op_q),
    .mem_ready  (mem_ready),
    .ir_write   (dec_ir_write),
    .pc_write   (dec_pc_write),
    .branch     (dec_branch),
    .mem_write  (dec_mem_write),
    .reg_write  (dec_reg_write),
    .reg_dst    (reg_dst),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_zext   (imm_zext),
    .result_src (result_src),
    .pc_src     (pc_src),
    .aluop      (aluop)
  );

  // FETCH follows mem_ready combinationally, so gate every write enable with reset.
  assign ir_write   = rst_n & dec_ir_write;
  assign mem_write  = rst_n & dec_mem_write;
  assign reg_write  = rst_n & dec_reg_write;
  assign pc_en      = rst_n & (dec_pc_write | (dec_branch & zero));
  assign alu_opcode = op_q;
  assign illegal_op = illegal_q;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expectations are queued
// per scenario and compared as the FSM steps through each instruction.
module tb_multicycle_controller;

  typedef struct packed {
    logic       ir_write;
    logic       pc_en;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] result_src;
    logic [1:0] pc_src;
    logic [1:0] aluop;
    logic       illegal_op;
  } outs_t;

  typedef struct packed {
    logic [63:0] tag;
    logic [3:0]  st;
    logic        mr;
    logic        zr;
    logic [5:0]  op;
    outs_t       outs;
    logic [5:0]  opc;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       pc_en, ir_write, mem_write, reg_write, reg_dst, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, pc_src, aluop;
  logic       imm_zext, illegal_op;
  logic [5:0] alu_opcode;
  logic [3:0] state;

  int         n_checks = 0;
  int         n_fail = 0;
  entry_t     sb[$];
  logic [5:0] sb_opq;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_zext   (imm_zext),
    .result_src (result_src),
    .pc_src     (pc_src),
    .aluop      (aluop),
    .alu_opcode (alu_opcode),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  function automatic outs_t got_outs();
    outs_t o;
    o = '{ir_write, pc_en, mem_write, reg_write, reg_dst, adr_src, alu_src_a, alu_src_b,
          imm_zext, result_src, pc_src, aluop, illegal_op};
    return o;
  endfunction

  // Expected controls per state, written straight from the state table.
  function automatic outs_t spec_outs(logic [3:0] st, logic [5:0] opq, logic zr, logic mr,
                                      logic ill);
    outs_t o;
    o = '0;
    o.illegal_op = ill;
    case (st)
      4'd0: begin
        o.ir_write = mr; o.pc_en = mr; o.alu_src_b = 2'b01; o.result_src = 2'b10;
      end
      4'd1: o.alu_src_b = 2'b11;
      4'd2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd3: o.adr_src = 1'b1;
      4'd4: begin o.result_src = 2'b01; o.reg_write = 1'b1; end
      4'd5: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
      4'd6: begin o.alu_src_a = 1'b1; o.aluop = 2'b11; end
      4'd7: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      4'd8: begin
        o.alu_src_a = 1'b1; o.aluop = 2'b01; o.pc_src = 2'b01; o.pc_en = zr;
      end
      4'd9: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.aluop = 2'b10;
        o.imm_zext = (opq == 6'b001100) || (opq == 6'b001101);
      end
      4'd10: o.reg_write = 1'b1;
      4'd11: begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push_exp(input logic [63:0] tag, input logic [3:0] st, input logic mr,
                          input logic zr, input logic [5:0] op, input logic ill);
    entry_t e;
    e.tag  = tag;
    e.st   = st;
    e.mr   = mr;
    e.zr   = zr;
    e.op   = op;
    e.outs = spec_outs(st, op, zr, mr, ill);
    e.opc  = sb_opq;
    if (st == 4'd1) sb_opq = op;
    sb.push_back(e);
  endtask

  task automatic drain();
    entry_t e;
    outs_t  g;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      opcode    = e.op;
      zero      = e.zr;
      mem_ready = e.mr;
      #1;
      g = got_outs();
      n_checks++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %0s state: got %0d expected %0d", e.tag, state, e.st);
      end
      n_checks++;
      if (g !== e.outs) begin
        n_fail++;
        $display("FAIL %0s outputs in state %0d: got %b expected %b", e.tag, e.st, g, e.outs);
      end
      n_checks++;
      if (alu_opcode !== e.opc) begin
        n_fail++;
        $display("FAIL %0s alu_opcode in state %0d: got %b expected %b", e.tag, e.st,
                 alu_opcode, e.opc);
      end
    end
  endtask

  task automatic test_reset();
    outs_t exp;
    rst_n = 1'b0; opcode = 6'b100011; zero = 1'b1; mem_ready = 1'b1;
    #3;
    exp = spec_outs(4'd0, 6'd0, 1'b1, 1'b1, 1'b0);
    exp.ir_write = 1'b0;
    exp.pc_en    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (state !== 4'd0) begin
        n_fail++; $display("FAIL reset state: got %0d expected 0", state);
      end
      n_checks++;
      if (got_outs() !== exp) begin
        n_fail++; $display("FAIL reset outputs: got %b expected %b", got_outs(), exp);
      end
      n_checks++;
      if (alu_opcode !== 6'd0) begin
        n_fail++; $display("FAIL reset alu_opcode: got %b expected 000000", alu_opcode);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    sb_opq = 6'd0;
  endtask

  task automatic test_lw();
    push_exp("lw", 0, 1, 0, 6'b100011, 0);
    push_exp("lw", 1, 1, 0, 6'b100011, 0);
    push_exp("lw", 2, 1, 0, 6'b100011, 0);
    push_exp("lw", 3, 1, 0, 6'b100011, 0);
    push_exp("lw", 4, 1, 0, 6'b100011, 0);
    drain();
  endtask

  task automatic test_rtype();
    push_exp("rtype", 0, 1, 1, 6'b000000, 0);
    push_exp("rtype", 1, 1, 1, 6'b000000, 0);
    push_exp("rtype", 6, 1, 1, 6'b000000, 0);
    push_exp("rtype", 7, 1, 1, 6'b000000, 0);
    drain();
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      push_exp("beq", 0, 1, 1'(z), 6'b000100, 0);
      push_exp("beq", 1, 1, 1'(z), 6'b000100, 0);
      push_exp("beq", 8, 1, 1'(z), 6'b000100, 0);
    end
    drain();
  endtask

  task automatic test_itype();
    logic [5:0] ops [3];
    ops[0] = 6'b001101; ops[1] = 6'b001000; ops[2] = 6'b001100;
    for (int i = 0; i < 3; i++) begin
      push_exp("itype", 0, 1, 0, ops[i], 0);
      push_exp("itype", 1, 1, 0, ops[i], 0);
      push_exp("itype", 9, 1, 0, ops[i], 0);
      push_exp("itype", 10, 1, 0, ops[i], 0);
    end
    drain();
  endtask

  task automatic test_sw_stall();
    push_exp("fstall", 0, 0, 0, 6'b101011, 0);
    push_exp("fstall", 0, 0, 0, 6'b101011, 0);
    push_exp("sw", 0, 1, 0, 6'b101011, 0);
    push_exp("sw", 1, 1, 0, 6'b101011, 0);
    push_exp("sw", 2, 1, 0, 6'b101011, 0);
    for (int i = 0; i < 3; i++) push_exp("sw", 5, 0, 0, 6'b101011, 0);
    push_exp("sw", 5, 1, 0, 6'b101011, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    push_exp("j", 0, 1, 0, 6'b000010, 0);
    push_exp("j", 1, 1, 0, 6'b000010, 0);
    push_exp("j", 11, 1, 0, 6'b000010, 0);
    push_exp("slti", 0, 1, 0, 6'b001010, 0);
    push_exp("slti", 1, 1, 0, 6'b001010, 0);
    push_exp("slti", 9, 1, 0, 6'b001010, 0);
    push_exp("slti", 10, 1, 0, 6'b001010, 0);
    drain();
  endtask

  task automatic test_illegal();
    push_exp("illegal", 0, 1, 0, 6'b111111, 0);
    push_exp("illegal", 1, 1, 0, 6'b111111, 0);
    push_exp("illegal", 0, 0, 0, 6'b111111, 1);
    push_exp("illegal", 0, 0, 0, 6'b111111, 0);
    drain();
  endtask

  task automatic test_reset_mid();
    push_exp("lwrst", 0, 1, 0, 6'b100011, 0);
    push_exp("lwrst", 1, 1, 0, 6'b100011, 0);
    push_exp("lwrst", 2, 1, 0, 6'b100011, 0);
    push_exp("lwrst", 3, 0, 0, 6'b100011, 0);
    drain();
    @(negedge clk);
    mem_ready = 1'b1;
    zero = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL midreset state: got %0d expected 0", state);
    end
    n_checks++;
    if ({ir_write, pc_en, mem_write, reg_write} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset enables: got %b expected 0000",
               {ir_write, pc_en, mem_write, reg_write});
    end
    n_checks++;
    if ({alu_opcode, illegal_op} !== 7'd0) begin
      n_fail++; $display("FAIL midreset opq/illegal: got %b expected 0", {alu_opcode, illegal_op});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    sb_opq = 6'd0;
    push_exp("postrst", 0, 1, 0, 6'b000000, 0);
    push_exp("postrst", 1, 1, 0, 6'b000000, 0);
    push_exp("postrst", 6, 1, 0, 6'b000000, 0);
    drain();
  endtask

  initial begin
    sb_opq = 6'd0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_itype();
    test_sw_stall();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
